task_stream_receiver: RTL

Receiver end of the task injection flit protocol. It consumes an application stream over a `rx`/`credit` handshake and decodes the application descriptor and per-task headers. It emits mapping-table, task-graph and header strobes, and writes task binaries into local memory through a grant-backpressured write port. It sits at the processing-element / mapper side, opposite the simulation task injector.

---
 rtl/task_stream_pkg.sv | 35 +++
 rtl/task_stream_wcount.sv | 31 +++
 rtl/task_stream_receiver.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/task_stream_pkg.sv
// task_stream_pkg: shared types for the task stream receiver.
// Holds the decoder state enum, the header word indices and the task header record.
package task_stream_pkg;

   // Decoder states, in stream order
   typedef enum logic [3:0] {
      S_DESCR_SIZE = 4'd0,
      S_TASK_CNT   = 4'd1,
      S_MAP        = 4'd2,
      S_TTT        = 4'd3,
      S_GRAPH      = 4'd4,
      S_TEXT       = 4'd5,
      S_DATA       = 4'd6,
      S_BSS        = 4'd7,
      S_ENTRY      = 4'd8,
      S_BINARY     = 4'd9,
      S_TASK_END   = 4'd10,
      S_ERROR      = 4'd11
   } rx_state_t;

   // Position of each word inside a task header block
   localparam logic [1:0] HDR_TEXT  = 2'd0;
   localparam logic [1:0] HDR_DATA  = 2'd1;
   localparam logic [1:0] HDR_BSS   = 2'd2;
   localparam logic [1:0] HDR_ENTRY = 2'd3;

   // Decoded per-task header
   typedef struct packed {
      logic [31:0] text;
      logic [31:0] data;
      logic [31:0] bss;
      logic [31:0] entry;
   } task_hdr_t;

endpackage

// File: rtl/task_stream_wcount.sv
// task_stream_wcount: loadable 32-bit down counter with zero / last flags.
// Load wins over decrement; decrement saturates at zero.
module task_stream_wcount
   import task_stream_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        i_load,
   input  logic [31:0] i_value,
   input  logic        i_dec,
   output logic        o_zero,
   output logic        o_last
);

   logic [31:0] r_count;

   // Count register: load a fresh total or step down by one
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_dec && (r_count != 32'd0)) begin
         r_count <= r_count - 32'd1;
      end
   end

   assign o_zero = (r_count == 32'd0);
   assign o_last = (r_count == 32'd1);

endmodule

// File: rtl/task_stream_receiver.sv
// task_stream_receiver: decodes an application stream (descriptor, mapping
// table, task graph, task headers and binaries) arriving over rx/credit.
// Optional protocol checking is enabled by defining TASKRX_CHECK_EN.
module task_stream_receiver
   import task_stream_pkg::*;
#(
   parameter  int FLIT_SIZE = 32,
   parameter  int MAX_TASKS = 32,
   parameter  int ADDR_W    = 16,
   localparam int TIDX_W    = $clog2(MAX_TASKS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 tbl_we_o,
   output logic [TIDX_W-1:0]    tbl_idx_o,
   output logic [31:0]          tbl_map_o,
   output logic [31:0]          tbl_ttt_o,
   output logic                 graph_we_o,
   output logic [15:0]          graph_idx_o,
   output logic [31:0]          graph_data_o,
   output logic                 hdr_valid_o,
   output logic [TIDX_W-1:0]    hdr_tidx_o,
   output logic [31:0]          hdr_text_o,
   output logic [31:0]          hdr_data_o,
   output logic [31:0]          hdr_bss_o,
   output logic [31:0]          hdr_entry_o,
   output logic                 mem_we_o,
   input  logic                 mem_gnt_i,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [31:0]          mem_data_o,
   output logic                 task_done_o,
   output logic                 app_done_o,
   output logic                 error_o
);

   localparam int CNT_GRAPH = 0;
   localparam int CNT_PAIR  = 1;
   localparam int CNT_TASK  = 2;
   localparam int CNT_BIN   = 3;
   localparam int N_CNT     = 4;

   rx_state_t         r_state;
   logic              r_run;
   logic              r_drain;
   logic [31:0]       r_map;
   logic [TIDX_W-1:0] r_pair_idx;
   logic [TIDX_W-1:0] r_task_idx;
   logic [15:0]       r_gidx;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_hdr_words [0:HDR_ENTRY-1];

   logic              r_tbl_we;
   logic [TIDX_W-1:0] r_tbl_idx;
   logic [31:0]       r_tbl_map;
   logic [31:0]       r_tbl_ttt;
   logic              r_graph_we;
   logic [15:0]       r_graph_idx;
   logic [31:0]       r_graph_data;
   logic              r_hdr_valid;
   logic [TIDX_W-1:0] r_hdr_tidx;
   task_hdr_t         r_hdr;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_data;
   logic              r_task_done;
   logic              r_app_done;

   logic [31:0]       w_flit;
   logic              w_stall;
   logic              w_credit;
   logic              w_acc;
   logic [31:0]       w_size;
   logic [31:0]       w_words;
   logic              w_cnt_bad;
   logic              w_size_bad;
   logic [N_CNT-1:0]  w_cnt_load;
   logic [N_CNT-1:0]  w_cnt_dec;
   logic [N_CNT-1:0]  w_cnt_zero;
   logic [N_CNT-1:0]  w_cnt_last;
   logic [31:0]       w_cnt_val [N_CNT];
   logic              w_unused_zero;

   // Only the low 32 bits of a flit carry protocol data
   assign w_flit = data_i[31:0];

   generate
      if (FLIT_SIZE > 32) begin : g_wide_flit
         logic w_unused_hi;
         assign w_unused_hi = |data_i[FLIT_SIZE-1:32];
      end
   endgenerate

   // A stalled binary write blocks the next flit; the grant opens it the same cycle.
   // While draining the last binary word the next flit would be a header, so hold off.
   assign w_stall  = r_mem_we && !mem_gnt_i;
   assign w_credit = r_run && !w_stall && !r_drain &&
                     (r_state != S_TASK_END) && (r_state != S_ERROR);
   assign w_acc    = rx_i && w_credit;

   // Binary length in words from the latched text and data sizes
   assign w_size  = r_hdr_words[HDR_TEXT] + r_hdr_words[HDR_DATA];
   assign w_words = w_size >> 2;

`ifdef TASKRX_CHECK_EN
   logic [31:0] w_size_now;
   assign w_size_now = r_hdr_words[HDR_TEXT] + w_flit;
   assign w_cnt_bad  = (w_flit == 32'd0) || (w_flit > 32'(MAX_TASKS));
   assign w_size_bad = (w_size_now[1:0] != 2'b00) ||
                       ({1'b0, w_size_now >> 2} > (33'd1 << ADDR_W));
   assign error_o    = (r_state == S_ERROR);
`else
   assign w_cnt_bad  = 1'b0;
   assign w_size_bad = 1'b0;
   assign error_o    = 1'b0;
`endif

   // Counter loads and decrements, keyed on the state that consumes each count
   assign w_cnt_val[CNT_GRAPH]  = w_flit;
   assign w_cnt_val[CNT_PAIR]   = w_flit;
   assign w_cnt_val[CNT_TASK]   = w_flit;
   assign w_cnt_val[CNT_BIN]    = w_words;
   assign w_cnt_load[CNT_GRAPH] = w_acc && (r_state == S_DESCR_SIZE);
   assign w_cnt_load[CNT_PAIR]  = w_acc && (r_state == S_TASK_CNT);
   assign w_cnt_load[CNT_TASK]  = w_acc && (r_state == S_TASK_CNT);
   assign w_cnt_load[CNT_BIN]   = w_acc && (r_state == S_ENTRY);
   assign w_cnt_dec[CNT_GRAPH]  = w_acc && (r_state == S_GRAPH);
   assign w_cnt_dec[CNT_PAIR]   = w_acc && (r_state == S_TTT);
   assign w_cnt_dec[CNT_TASK]   = (r_state == S_TASK_END);
   assign w_cnt_dec[CNT_BIN]    = w_acc && (r_state == S_BINARY);

   genvar gi;
   generate
      for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
         task_stream_wcount u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .i_load  (w_cnt_load[gi]),
            .i_value (w_cnt_val[gi]),
            .i_dec   (w_cnt_dec[gi]),
            .o_zero  (w_cnt_zero[gi]),
            .o_last  (w_cnt_last[gi])
         );
      end
   endgenerate

   assign w_unused_zero = &{1'b0, w_cnt_zero[CNT_PAIR], w_cnt_zero[CNT_TASK], w_cnt_zero[CNT_BIN]};

   // Stream decoder: walks the stream layout and drives all registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state                <= S_DESCR_SIZE;
         r_run                  <= 1'b0;
         r_drain                <= 1'b0;
         r_map                  <= '0;
         r_pair_idx             <= '0;
         r_task_idx             <= '0;
         r_gidx                 <= '0;
         r_addr                 <= '0;
         r_hdr_words[HDR_TEXT]  <= '0;
         r_hdr_words[HDR_DATA]  <= '0;
         r_hdr_words[HDR_BSS]   <= '0;
         r_tbl_we               <= 1'b0;
         r_tbl_idx              <= '0;
         r_tbl_map              <= '0;
         r_tbl_ttt              <= '0;
         r_graph_we             <= 1'b0;
         r_graph_idx            <= '0;
         r_graph_data           <= '0;
         r_hdr_valid            <= 1'b0;
         r_hdr_tidx             <= '0;
         r_hdr                  <= '0;
         r_mem_we               <= 1'b0;
         r_mem_addr             <= '0;
         r_mem_data             <= '0;
         r_task_done            <= 1'b0;
         r_app_done             <= 1'b0;
      end else begin
         r_run       <= 1'b1;
         r_tbl_we    <= 1'b0;
         r_graph_we  <= 1'b0;
         r_hdr_valid <= 1'b0;
         r_task_done <= 1'b0;
         r_app_done  <= 1'b0;
         if (r_mem_we && mem_gnt_i) begin
            r_mem_we <= 1'b0;
         end

         case (r_state)
            S_DESCR_SIZE: if (w_acc) begin
               r_gidx  <= '0;
               r_state <= S_TASK_CNT;
            end
            S_TASK_CNT: if (w_acc) begin
               r_pair_idx <= '0;
               r_task_idx <= '0;
               if (w_cnt_bad) begin
                  r_state <= S_ERROR;
               end else if (w_flit == 32'd0) begin
                  r_app_done <= 1'b1;
                  r_state    <= S_DESCR_SIZE;
               end else begin
                  r_state <= S_MAP;
               end
            end
            S_MAP: if (w_acc) begin
               r_map   <= w_flit;
               r_state <= S_TTT;
            end
            S_TTT: if (w_acc) begin
               r_tbl_we   <= 1'b1;
               r_tbl_idx  <= r_pair_idx;
               r_tbl_map  <= r_map;
               r_tbl_ttt  <= w_flit;
               r_pair_idx <= r_pair_idx + TIDX_W'(1);
               if (!w_cnt_last[CNT_PAIR]) begin
                  r_state <= S_MAP;
               end else if (!w_cnt_zero[CNT_GRAPH]) begin
                  r_state <= S_GRAPH;
               end else begin
                  r_state <= S_TEXT;
               end
            end
            S_GRAPH: if (w_acc) begin
               r_graph_we   <= 1'b1;
               r_graph_idx  <= r_gidx;
               r_graph_data <= w_flit;
               r_gidx       <= r_gidx + 16'd1;
               if (w_cnt_last[CNT_GRAPH]) begin
                  r_state <= S_TEXT;
               end
            end
            S_TEXT: if (w_acc) begin
               r_hdr_words[HDR_TEXT] <= w_flit;
               r_state               <= S_DATA;
            end
            S_DATA: if (w_acc) begin
               r_hdr_words[HDR_DATA] <= w_flit;
               r_state               <= w_size_bad ? S_ERROR : S_BSS;
            end
            S_BSS: if (w_acc) begin
               r_hdr_words[HDR_BSS] <= w_flit;
               r_state              <= S_ENTRY;
            end
            S_ENTRY: if (w_acc) begin
               r_hdr_valid <= 1'b1;
               r_hdr_tidx  <= r_task_idx;
               r_hdr.text  <= r_hdr_words[HDR_TEXT];
               r_hdr.data  <= r_hdr_words[HDR_DATA];
               r_hdr.bss   <= r_hdr_words[HDR_BSS];
               r_hdr.entry <= w_flit;
               r_addr      <= '0;
               if (w_words == 32'd0) begin
                  r_task_done <= 1'b1;
                  r_state     <= S_TASK_END;
               end else begin
                  r_state <= S_BINARY;
               end
            end
            S_BINARY: begin
               if (w_acc) begin
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= r_addr;
                  r_mem_data <= w_flit;
                  r_addr     <= r_addr + ADDR_W'(1);
                  if (w_cnt_last[CNT_BIN]) begin
                     r_drain <= 1'b1;
                  end
               end else if (r_drain && r_mem_we && mem_gnt_i) begin
                  // Last word granted: the task is complete in memory
                  r_drain     <= 1'b0;
                  r_task_done <= 1'b1;
                  r_state     <= S_TASK_END;
               end
            end
            S_TASK_END: begin
               r_task_idx <= r_task_idx + TIDX_W'(1);
               if (w_cnt_last[CNT_TASK]) begin
                  r_app_done <= 1'b1;
                  r_state    <= S_DESCR_SIZE;
               end else begin
                  r_state <= S_TEXT;
               end
            end
            S_ERROR: r_state <= S_ERROR;
            default: r_state <= S_DESCR_SIZE;
         endcase
      end
   end

   assign credit_o     = w_credit;
   assign tbl_we_o     = r_tbl_we;
   assign tbl_idx_o    = r_tbl_idx;
   assign tbl_map_o    = r_tbl_map;
   assign tbl_ttt_o    = r_tbl_ttt;
   assign graph_we_o   = r_graph_we;
   assign graph_idx_o  = r_graph_idx;
   assign graph_data_o = r_graph_data;
   assign hdr_valid_o  = r_hdr_valid;
   assign hdr_tidx_o   = r_hdr_tidx;
   assign hdr_text_o   = r_hdr.text;
   assign hdr_data_o   = r_hdr.data;
   assign hdr_bss_o    = r_hdr.bss;
   assign hdr_entry_o  = r_hdr.entry;
   assign mem_we_o     = r_mem_we;
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;
   assign task_done_o  = r_task_done;
   assign app_done_o   = r_app_done;

endmodule
